// File: rtl/bf_pkg.sv
// Shared definitions for the Brainfuck core phase sequencer.
//  - seq_state_t : sequencer FSM states
//  - PH_*        : phase indices into the internal strobe vector; the core
//                  uses the same indices when it decodes the phase bus.
package bf_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        READ     = 3'd2,
        EXEC     = 3'd3,
        WAIT_OUT = 3'd4,
        WRITE    = 3'd5,
        HALTED   = 3'd6
    } seq_state_t;

    localparam int PH_FETCH = 0;
    localparam int PH_READ  = 1;
    localparam int PH_EXEC  = 2;
    localparam int PH_WRITE = 3;
    localparam int PH_NUM   = 4;

endpackage

// File: rtl/bf_tick_gen.sv
// Slow phase tick generator.
// Counts clk cycles 0..TICK_DIV-1 and asserts tick for the one clk in which
// the counter sits at TICK_DIV-1; the counter then wraps to 0.
// TICK_DIV = 1 gives a tick on every clk.
// Ports:
//  clk   in  system clock
//  rst   in  synchronous reset, active-high (counter returns to 0)
//  tick  out one-clk pulse every TICK_DIV clks
module bf_tick_gen #(
    parameter int TICK_DIV = 50_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bf_phase_sequencer.sv
// Per-instruction phase sequencer for the Brainfuck core.
// Walks FETCH -> READ -> EXEC -> [WAIT_OUT] -> WRITE, one state per slow tick,
// and emits one-clk phase strobes plus RAM enables. Supports free-run
// (run_en), single-step (step_req) and a permanent halt (halt_in).
// Optional build macro: BF_SEQ_PERF_EN builds the saturating performance
// counters; without it instr_cnt/stall_cnt are tied to 0.
// Ports:
//  clk, rst             clock, synchronous active-high reset
//  run_en               level, run instructions back to back
//  step_req             1-clk pulse, run one instruction when idle
//  halt_in              program finished / ROM overrun
//  out_req, out_ready   '.' op in EXEC, serial TX ready
//  ph_fetch..ph_write   one-clk phase strobes, 1 clk after the entering tick
//  ram_ce, ram_we       RAM enables (READ/WRITE, WRITE only)
//  out_valid            char handed to TX, in the clk of the releasing tick
//  busy, halted         status
//  instr_cnt, stall_cnt retired instructions, WAIT_OUT tick periods
module bf_phase_sequencer
    import bf_pkg::*;
#(
    parameter int TICK_DIV = 50_000,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_en,
    input  logic             step_req,
    input  logic             halt_in,
    input  logic             out_req,
    input  logic             out_ready,
    output logic             ph_fetch,
    output logic             ph_read,
    output logic             ph_exec,
    output logic             ph_write,
    output logic             ram_ce,
    output logic             ram_we,
    output logic             out_valid,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    logic              tick;
    seq_state_t        state;
    seq_state_t        nxt;
    logic              step_pending;
    logic              step_take;
    logic [PH_NUM-1:0] ph;

    bf_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (halt_in)                    nxt = HALTED;
                else if (run_en || step_pending) nxt = FETCH;
            end
            FETCH:    nxt = READ;
            READ:     nxt = EXEC;
            EXEC:     nxt = out_req ? WAIT_OUT : WRITE;
            WAIT_OUT: if (out_ready) nxt = WRITE;
            WRITE: begin
                if (halt_in)                    nxt = HALTED;
                else if (run_en || step_pending) nxt = FETCH;
                else                             nxt = IDLE;
            end
            HALTED:   nxt = HALTED;
            default:  nxt = IDLE;
        endcase
    end

    // A pending step is consumed by any IDLE->FETCH start, but at WRITE only
    // when it is what keeps the sequencer going (run_en low).
    assign step_take = tick && (nxt == FETCH) &&
                       ((state == IDLE) || (state == WRITE && !run_en));

    // The TX handshake completes in the clk of the tick that leaves WAIT_OUT.
    assign out_valid = tick && (state == WAIT_OUT) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            step_pending <= 1'b0;
            ph           <= '0;
            ram_ce       <= 1'b0;
            ram_we       <= 1'b0;
            busy         <= 1'b0;
            halted       <= 1'b0;
        end else begin
            ph <= '0;
            if (tick) begin
                state        <= nxt;
                // No state self-loops except WAIT_OUT/IDLE/HALTED, which have
                // no strobe, so decoding nxt gives exactly one strobe per entry.
                ph[PH_FETCH] <= (nxt == FETCH);
                ph[PH_READ]  <= (nxt == READ);
                ph[PH_EXEC]  <= (nxt == EXEC);
                ph[PH_WRITE] <= (nxt == WRITE);
                ram_ce       <= (nxt == READ) || (nxt == WRITE);
                ram_we       <= (nxt == WRITE);
                busy         <= (nxt != IDLE) && (nxt != HALTED);
                halted       <= (nxt == HALTED);
            end
            // A request arriving while one is already pending (or in the clk
            // it is consumed) is dropped.
            if (step_take) begin
                step_pending <= 1'b0;
            end else if (step_req && state != HALTED) begin
                step_pending <= 1'b1;
            end
        end
    end

    assign ph_fetch = ph[PH_FETCH];
    assign ph_read  = ph[PH_READ];
    assign ph_exec  = ph[PH_EXEC];
    assign ph_write = ph[PH_WRITE];

`ifdef BF_SEQ_PERF_EN
    logic [CNT_W-1:0] instr_q;
    logic [CNT_W-1:0] stall_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            stall_q <= '0;
        end else if (tick) begin
            // Retire on entry to WRITE so the count moves with ph_write.
            if (nxt == WRITE) begin
                instr_q <= sat_inc(instr_q);
            end
            if (state == WAIT_OUT && !out_ready) begin
                stall_q <= sat_inc(stall_q);
            end
        end
    end

    assign instr_cnt = instr_q;
    assign stall_cnt = stall_q;
`else
    assign instr_cnt = '0;
    assign stall_cnt = '0;
`endif

endmodule
